// File: rtl/rv32imc_types.sv
// rtl/rv32imc_types.sv - shared types and config register addresses for the interrupt controller
package rv32imc_types;

  typedef enum logic [1:0] {INT_IDLE, INT_REQ, INT_ACTIVE} int_state_t;

  localparam logic [1:0] INT_CFG_MASK = 2'd0;
  localparam logic [1:0] INT_CFG_PEND = 2'd1;
  localparam logic [1:0] INT_CFG_STAT = 2'd2;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - combinational fixed-priority encoder, lowest set index wins
import rv32imc_types::*;

module int_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   id
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 5'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - pending/mask interrupt controller feeding the core; INT_CTRL_EDGE_DETECT_EN selects edge mode
import rv32imc_types::*;

module int_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               signal_interrupt,
  output logic [31:0]        interrupt_PC,
  input  logic               int_accepted,
  input  logic               interrupt_serviced,
  output logic               irq_active,
  output logic [4:0]         active_id
);

  int_state_t         state, state_next;
  logic [NUM_IRQ-1:0] pending, mask, irq_event, clr, eligible;
  logic               sig_next, act_next, enc_valid;
  logic [31:0]        pc_next;
  logic [4:0]         id_next, enc_id;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

`ifdef INT_CTRL_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_q;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq;
  end
  assign irq_event = irq & ~irq_q;
`else
  assign irq_event = irq;
`endif

  assign eligible = pending & mask;

  int_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (eligible),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_comb begin
    clr = '0;
    if (cfg_we && cfg_addr == INT_CFG_PEND) clr = cfg_wdata[NUM_IRQ-1:0];
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (state == INT_REQ && int_accepted && active_id == 5'(i)) clr[i] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle event always survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr) | irq_event;
      if (cfg_we && cfg_addr == INT_CFG_MASK) mask <= cfg_wdata[NUM_IRQ-1:0];
    end
  end

  always_comb begin
    state_next = state;
    sig_next   = signal_interrupt;
    pc_next    = interrupt_PC;
    act_next   = irq_active;
    id_next    = active_id;
    case (state)
      INT_IDLE: begin
        if (enc_valid) begin
          state_next = INT_REQ;
          sig_next   = 1'b1;
          pc_next    = VEC_BASE + 32'(enc_id) * 32'(VEC_STRIDE);
          id_next    = enc_id;
        end
      end
      INT_REQ: begin
        if (int_accepted) begin
          state_next = INT_ACTIVE;
          sig_next   = 1'b0;
          act_next   = 1'b1;
        end
      end
      INT_ACTIVE: begin
        if (interrupt_serviced) begin
          state_next = INT_IDLE;
          act_next   = 1'b0;
          id_next    = '0;
        end
      end
      default: state_next = INT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= INT_IDLE;
      signal_interrupt <= 1'b0;
      interrupt_PC     <= '0;
      irq_active       <= 1'b0;
      active_id        <= '0;
    end else begin
      state            <= state_next;
      signal_interrupt <= sig_next;
      interrupt_PC     <= pc_next;
      irq_active       <= act_next;
      active_id        <= id_next;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      INT_CFG_MASK: cfg_rdata[NUM_IRQ-1:0] = mask;
      INT_CFG_PEND: cfg_rdata[NUM_IRQ-1:0] = pending;
      INT_CFG_STAT: cfg_rdata = {24'b0, irq_active, signal_interrupt, 1'b0, active_id};
      default:      cfg_rdata = '0;
    endcase
  end

endmodule
